// File: rtl/drt_enumerator_if.sv
// Wishbone read-master bus between drt_enumerator and the interconnect port of the DRT slave.
interface drt_enumerator_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_int_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_int_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_int_i
  );
endinterface

// File: rtl/drt_enumerator.sv
// Walks the Device ROM Table over Wishbone and returns the first entry whose masked ID matches.
// Each word: REQ until ack (timed), then REL until ack drops; a scan ends with a one-cycle done pulse.
module drt_enumerator #(
  parameter logic [31:0] DRT_BASE      = 32'h00000000,
  parameter logic [15:0] EXPECT_DRT_ID = 16'h0001,
  parameter logic [31:0] ID_MASK       = 32'h0000FFFF,
  parameter int          MAX_DEVICES   = 16,
  parameter logic [15:0] TIMEOUT       = 16'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       search_id,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              error,
  output logic [15:0]       drt_version,
  output logic [31:0]       num_devices,
  output logic [7:0]        dev_index,
  output logic [31:0]       dev_info,
  output logic [31:0]       dev_mem_off,
  output logic [31:0]       dev_size,
  drt_enumerator_if.master  wbm
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DEV_ID, S_INFO, S_MEM, S_SIZE, S_FIN
  } state_t;

  localparam logic [31:0] MAX_DEV32 = 32'(MAX_DEVICES);

  state_t      state_q, state_d;
  logic        rel_q, rel_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] count_q, count_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] sid_q, sid_d;
  logic        found_q, found_d;
  logic        error_q, error_d;
  logic [15:0] ver_q, ver_d;
  logic [31:0] ndev_q, ndev_d;
  logic [7:0]  dev_index_q, dev_index_d;
  logic [31:0] info_q, info_d;
  logic [31:0] moff_q, moff_d;
  logic [31:0] size_q, size_d;

  logic        bus_phase;
  logic [31:0] ent_base;
  logic [31:0] adr;
  logic [31:0] clamped;
  logic        id_match;
  logic        last_entry;
  logic        unused_int;

  assign unused_int = wbm.wbm_int_i;

  assign bus_phase  = (state_q != S_IDLE) && (state_q != S_FIN);
  assign ent_base   = DRT_BASE + 32'd8 + ({24'd0, idx_q} << 3);
  assign clamped    = (rdat_q > MAX_DEV32) ? MAX_DEV32 : rdat_q;
  assign id_match   = (rdat_q & ID_MASK) == (sid_q & ID_MASK);
  assign last_entry = ({24'd0, idx_q} + 32'd1) == count_q;

  always_comb begin
    adr = 32'd0;
    case (state_q)
      S_HDR0:   adr = DRT_BASE;
      S_HDR1:   adr = DRT_BASE + 32'd1;
      S_DEV_ID: adr = ent_base;
      S_INFO:   adr = ent_base + 32'd1;
      S_MEM:    adr = ent_base + 32'd2;
      S_SIZE:   adr = ent_base + 32'd3;
      default:  adr = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rel_q       <= 1'b0;
      tcnt_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      rdat_q      <= '0;
      sid_q       <= '0;
      found_q     <= 1'b0;
      error_q     <= 1'b0;
      ver_q       <= '0;
      ndev_q      <= '0;
      dev_index_q <= '0;
      info_q      <= '0;
      moff_q      <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      rel_q       <= rel_d;
      tcnt_q      <= tcnt_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      rdat_q      <= rdat_d;
      sid_q       <= sid_d;
      found_q     <= found_d;
      error_q     <= error_d;
      ver_q       <= ver_d;
      ndev_q      <= ndev_d;
      dev_index_q <= dev_index_d;
      info_q      <= info_d;
      moff_q      <= moff_d;
      size_q      <= size_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rel_d       = rel_q;
    tcnt_d      = tcnt_q;
    idx_d       = idx_q;
    count_d     = count_q;
    rdat_d      = rdat_q;
    sid_d       = sid_q;
    found_d     = found_q;
    error_d     = error_q;
    ver_d       = ver_q;
    ndev_d      = ndev_q;
    dev_index_d = dev_index_q;
    info_d      = info_q;
    moff_d      = moff_q;
    size_d      = size_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sid_d       = search_id;
          found_d     = 1'b0;
          error_d     = 1'b0;
          dev_index_d = '0;
          info_d      = '0;
          moff_d      = '0;
          size_d      = '0;
          rel_d       = 1'b0;
          tcnt_d      = '0;
          state_d     = S_HDR0;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!rel_q) begin
          if (wbm.wbm_ack_i) begin
            rdat_d = wbm.wbm_dat_i;
            rel_d  = 1'b1;
          end else if (tcnt_q == TIMEOUT - 16'd1) begin
            error_d = 1'b1;
            state_d = S_FIN;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end else if (!wbm.wbm_ack_i) begin
          // Captured word is acted on only once the slave has released ack.
          rel_d  = 1'b0;
          tcnt_d = '0;
          case (state_q)
            S_HDR0: begin
              ver_d = rdat_q[15:0];
              if (rdat_q[31:16] != EXPECT_DRT_ID) begin
                error_d = 1'b1;
                state_d = S_FIN;
              end else begin
                state_d = S_HDR1;
              end
            end
            S_HDR1: begin
              ndev_d  = rdat_q;
              count_d = clamped;
              idx_d   = '0;
              state_d = (clamped == 32'd0) ? S_FIN : S_DEV_ID;
            end
            S_DEV_ID: begin
              if (id_match) begin
                dev_index_d = idx_q;
                state_d     = S_INFO;
              end else if (last_entry) begin
                state_d = S_FIN;
              end else begin
                idx_d = idx_q + 8'd1;
              end
            end
            S_INFO: begin
              info_d  = rdat_q;
              state_d = S_MEM;
            end
            S_MEM: begin
              moff_d  = rdat_q;
              state_d = S_SIZE;
            end
            S_SIZE: begin
              size_d  = rdat_q;
              found_d = 1'b1;
              state_d = S_FIN;
            end
            default: state_d = S_FIN;
          endcase
        end
      end
    endcase
  end

  assign busy        = bus_phase;
  assign done        = (state_q == S_FIN);
  assign found       = found_q;
  assign error       = error_q;
  assign drt_version = ver_q;
  assign num_devices = ndev_q;
  assign dev_index   = dev_index_q;
  assign dev_info    = info_q;
  assign dev_mem_off = moff_q;
  assign dev_size    = size_q;

  assign wbm.wbm_cyc_o = bus_phase;
  assign wbm.wbm_stb_o = bus_phase && !rel_q;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_sel_o = 4'hF;
  assign wbm.wbm_adr_o = adr;
  assign wbm.wbm_dat_o = 32'd0;

endmodule

// File: tb/tb_drt_enumerator.sv
// Directed bench for drt_enumerator against a behavioural DRT slave with programmable ack latency.
module tb_drt_enumerator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] search_id = 32'd0;
  logic        busy, done, found, error;
  logic [15:0] drt_version;
  logic [31:0] num_devices;
  logic [7:0]  dev_index;
  logic [31:0] dev_info, dev_mem_off, dev_size;

  drt_enumerator_if bus();

  drt_enumerator dut (
    .clk(clk), .rst(rst), .start(start), .search_id(search_id),
    .busy(busy), .done(done), .found(found), .error(error),
    .drt_version(drt_version), .num_devices(num_devices), .dev_index(dev_index),
    .dev_info(dev_info), .dev_mem_off(dev_mem_off), .dev_size(dev_size),
    .wbm(bus)
  );

  always #5 clk = ~clk;

  // Behavioural slave: ack after lat cycles of stb, held until stb drops.
  logic [31:0] mem [64];
  int          lat = 1;
  logic        never_ack = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rd_dat = 32'd0;
  int          lcnt = 0;
  int          nreads = 0;
  int          rd_cnt [64];

  always @(posedge clk) begin
    if (rst) begin
      ack  <= 1'b0;
      lcnt <= 0;
    end else if (never_ack) begin
      ack <= 1'b0;
    end else if (bus.wbm_stb_o && !ack) begin
      if (lcnt + 1 >= lat) begin
        ack    <= 1'b1;
        rd_dat <= mem[bus.wbm_adr_o[5:0]];
        lcnt   <= 0;
        nreads <= nreads + 1;
        rd_cnt[bus.wbm_adr_o[5:0]] <= rd_cnt[bus.wbm_adr_o[5:0]] + 1;
      end else begin
        lcnt <= lcnt + 1;
      end
    end else if (!bus.wbm_stb_o) begin
      ack  <= 1'b0;
      lcnt <= 0;
    end
  end

  assign bus.wbm_ack_i = ack;
  assign bus.wbm_dat_i = rd_dat;
  assign bus.wbm_int_i = 1'b0;

  int   stb_cnt = 0;
  int   done_cnt = 0;
  int   viol = 0;
  logic prev_stb = 1'b0;

  always @(posedge clk) begin
    prev_stb <= bus.wbm_stb_o;
    if (bus.wbm_stb_o) stb_cnt <= stb_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.wbm_stb_o && !prev_stb && bus.wbm_ack_i) viol <= viol + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int reads0, stb0, done0, viol0;
  int rd_snap [64];

  task automatic load_drt();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = 32'h00010004;
    mem[1]  = 32'd2;
    mem[8]  = 32'h00000003;
    mem[9]  = 32'hDEAD0001;
    mem[10] = 32'hDEAD0002;
    mem[11] = 32'hDEAD0003;
    mem[16] = 32'h00000005;
    mem[17] = 32'h11110000;
    mem[18] = 32'h22220000;
    mem[19] = 32'h33330000;
  endtask

  // Pulses start and waits for done; leaves the bench at the negedge where done is high.
  task automatic run_scan(input logic [31:0] sid);
    @(negedge clk);
    reads0 = nreads;
    stb0   = stb_cnt;
    done0  = done_cnt;
    viol0  = viol;
    for (int i = 0; i < 64; i++) rd_snap[i] = rd_cnt[i];
    start     = 1'b1;
    search_id = sid;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - done0), 32'd1);
  endtask

  initial begin
    load_drt();
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_sel", 32'(bus.wbm_sel_o), 32'h0000000F);
    chk("rst_info", dev_info, 32'd0);
    rst = 1'b0;

    // Match on the second entry.
    run_scan(32'd5);
    chk("t1_found", 32'(found), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_index", 32'(dev_index), 32'd1);
    chk("t1_version", 32'(drt_version), 32'd4);
    chk("t1_ndev", num_devices, 32'd2);
    chk("t1_info", dev_info, 32'h11110000);
    chk("t1_moff", dev_mem_off, 32'h22220000);
    chk("t1_size", dev_size, 32'h33330000);
    chk("t1_reads", 32'(nreads - reads0), 32'd7);
    after_done();

    // No match: both IDs read, dev_* cleared from the previous scan.
    run_scan(32'h00000009);
    chk("t2_found", 32'(found), 32'd0);
    chk("t2_error", 32'(error), 32'd0);
    chk("t2_info", dev_info, 32'd0);
    chk("t2_size", dev_size, 32'd0);
    chk("t2_reads", 32'(nreads - reads0), 32'd4);
    after_done();

    // Upper bits outside ID_MASK are ignored.
    run_scan(32'hABCD0005);
    chk("mask_found", 32'(found), 32'd1);
    chk("mask_index", 32'(dev_index), 32'd1);
    after_done();

    // First match wins.
    mem[8] = 32'h12340005;
    run_scan(32'd5);
    chk("first_found", 32'(found), 32'd1);
    chk("first_index", 32'(dev_index), 32'd0);
    chk("first_info", dev_info, 32'hDEAD0001);
    chk("first_reads", 32'(nreads - reads0), 32'd6);
    after_done();
    mem[8] = 32'h00000003;

    // Bad header ID; start raised alongside done must be ignored.
    mem[0] = 32'h00020001;
    run_scan(32'd5);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_found", 32'(found), 32'd0);
    chk("t3_version", 32'(drt_version), 32'd1);
    chk("t3_reads", 32'(nreads - reads0), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_start_at_done", 32'(busy), 32'd0);
    chk("t3_done_count", 32'(done_cnt - done0), 32'd1);
    mem[0] = 32'h00010004;

    // Slave never acks.
    never_ack = 1'b1;
    run_scan(32'd5);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    after_done();
    chk("t4_stb_cycles", 32'(stb_cnt - stb0), 32'd255);
    never_ack = 1'b0;

    // Zero device count.
    mem[1] = 32'd0;
    run_scan(32'd5);
    chk("t4b_found", 32'(found), 32'd0);
    chk("t4b_error", 32'(error), 32'd0);
    chk("t4b_reads", 32'(nreads - reads0), 32'd2);
    after_done();
    mem[1] = 32'd2;

    // Slow slave with held ack.
    lat = 3;
    run_scan(32'd5);
    chk("t5_found", 32'(found), 32'd1);
    chk("t5_size", dev_size, 32'h33330000);
    after_done();
    chk("t5_stb_under_ack", 32'(viol - viol0), 32'd0);
    chk("t5_rd_hdr0", 32'(rd_cnt[0] - rd_snap[0]), 32'd1);
    chk("t5_rd_hdr1", 32'(rd_cnt[1] - rd_snap[1]), 32'd1);
    chk("t5_rd_id0", 32'(rd_cnt[8] - rd_snap[8]), 32'd1);
    chk("t5_rd_id1", 32'(rd_cnt[16] - rd_snap[16]), 32'd1);
    chk("t5_rd_info", 32'(rd_cnt[17] - rd_snap[17]), 32'd1);
    chk("t5_rd_moff", 32'(rd_cnt[18] - rd_snap[18]), 32'd1);
    chk("t5_rd_size", 32'(rd_cnt[19] - rd_snap[19]), 32'd1);
    chk("t5_rd_skip", 32'(rd_cnt[9] - rd_snap[9]), 32'd0);
    lat = 1;

    // Reset during the first device-ID read.
    @(negedge clk);
    done0 = done_cnt;
    start     = 1'b1;
    search_id = 32'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(bus.wbm_stb_o && bus.wbm_adr_o == 32'd8); i++) @(negedge clk);
    chk("t6_reached_devid", 32'(bus.wbm_stb_o && bus.wbm_adr_o == 32'd8), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("t6_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - done0), 32'd0);
    run_scan(32'd5);
    chk("t6_restart_found", 32'(found), 32'd1);
    chk("t6_restart_index", 32'(dev_index), 32'd1);
    after_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
